// File: rtl/snail_pkg.sv
// Shared constants and helpers for the parametrised snail sequence detector.
package snail_pkg;

  localparam bit SNAIL_OVERLAP    = 1'b1;
  localparam bit SNAIL_NONOVERLAP = 1'b0;
  localparam bit SNAIL_MEALY      = 1'b1;
  localparam bit SNAIL_MOORE      = 1'b0;

  localparam logic [3:0] SNAIL_PAT_DEFAULT = 4'b1011;

  // Width of the fill counter: must represent 0..pat_w inclusive.
  function automatic int unsigned snail_fw(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // ASCII state label "S<k>" for waveform viewing.
  function automatic logic [63:0] snail_state_name(input int unsigned k);
    logic [63:0] s;
    s = '0;
    if (k >= 10) begin
      s = {40'd0, 8'h53, 8'(8'h30 + k / 10), 8'(8'h30 + k % 10)};
    end else begin
      s = {48'd0, 8'h53, 8'(8'h30 + k)};
    end
    return s;
  endfunction

endpackage

// File: rtl/snail_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module snail_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         _rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/snail_seq_detector_param.sv
// Serial pattern detector with run-time reloadable pattern, selectable
// overlap / output timing, and a saturating match counter.
module snail_seq_detector_param
  import snail_pkg::*;
#(
  parameter  int unsigned      PAT_W   = 4,
  parameter  logic [PAT_W-1:0] PATTERN = PAT_W'(SNAIL_PAT_DEFAULT),
  parameter  bit               OVERLAP = SNAIL_OVERLAP,
  parameter  bit               MEALY   = SNAIL_MEALY,
  parameter  int unsigned      CNT_W   = 8,
  localparam int unsigned      FW      = snail_fw(PAT_W)
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             en,
  input  logic             D,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             Q,
  output logic [CNT_W-1:0] match_cnt,
  output logic [FW-1:0]    fill
);

  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic             r_q;
  logic [63:0]      txstate;

  logic             w_sample;
  logic [PAT_W-1:0] w_nhist;
  logic [FW-1:0]    w_nfill;
  logic             w_hit;
  logic [FW-1:0]    w_fill_step;
  logic             w_unused;

  assign w_sample    = en & ~pat_ld;
  assign w_nhist     = {r_hist[PAT_W-2:0], D};
  assign w_nfill     = (r_fill == FW'(PAT_W)) ? r_fill : r_fill + FW'(1);
  assign w_hit       = w_sample && (w_nfill == FW'(PAT_W)) && (w_nhist == r_pat);
  // Non-overlapping mode restarts collection from S0 after every match.
  assign w_fill_step = (w_hit && !OVERLAP) ? '0 : w_nfill;

  // fill is the FSM state (S0..S_PAT_W); pattern load resets collection.
  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      r_pat   <= PATTERN;
      r_hist  <= '0;
      r_fill  <= '0;
      r_q     <= 1'b0;
      txstate <= snail_state_name(32'd0);
    end else if (pat_ld) begin
      r_pat   <= pat_in;
      r_hist  <= '0;
      r_fill  <= '0;
      r_q     <= 1'b0;
      txstate <= snail_state_name(32'd0);
    end else begin
      r_q <= w_hit;
      if (en) begin
        r_hist  <= w_nhist;
        r_fill  <= w_fill_step;
        txstate <= snail_state_name(32'(w_fill_step));
      end
    end
  end

  snail_sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    ._rst (_rst),
    .inc  (w_hit),
    .clr  (cnt_clr),
    .cnt  (match_cnt)
  );

  assign Q        = MEALY ? (w_hit & ~_rst) : r_q;
  assign fill     = r_fill;
  assign w_unused = ^txstate;

endmodule

// File: tb/tb_snail_seq_detector_param.sv
// Bench for snail_seq_detector_param: four parameter variants share one
// stimulus stream and are checked against a string-based reference model.
module tb_snail_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, d, pat_ld, cnt_clr;
  logic [3:0] pat_in;

  logic       q0, q1, q2, q3;
  logic [2:0] f0, f1, f2, f3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;

  logic       q_a    [4];
  logic [2:0] fill_a [4];
  logic [7:0] cnt_a  [4];

  assign q_a[0] = q0; assign q_a[1] = q1; assign q_a[2] = q2; assign q_a[3] = q3;
  assign fill_a[0] = f0; assign fill_a[1] = f1; assign fill_a[2] = f2; assign fill_a[3] = f3;
  assign cnt_a[0] = c0; assign cnt_a[1] = c1; assign cnt_a[2] = c2; assign cnt_a[3] = {6'd0, c3};

  always #5 clk = ~clk;

  snail_seq_detector_param u0 (
    .clk(clk), ._rst(rst), .en(en), .D(d), .pat_ld(pat_ld), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .Q(q0), .match_cnt(c0), .fill(f0));

  snail_seq_detector_param #(.OVERLAP(1'b0)) u1 (
    .clk(clk), ._rst(rst), .en(en), .D(d), .pat_ld(pat_ld), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .Q(q1), .match_cnt(c1), .fill(f1));

  snail_seq_detector_param #(.MEALY(1'b0)) u2 (
    .clk(clk), ._rst(rst), .en(en), .D(d), .pat_ld(pat_ld), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .Q(q2), .match_cnt(c2), .fill(f2));

  snail_seq_detector_param #(.CNT_W(2)) u3 (
    .clk(clk), ._rst(rst), .en(en), .D(d), .pat_ld(pat_ld), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .Q(q3), .match_cnt(c3), .fill(f3));

  localparam bit IS_OV    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam bit IS_MEALY [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam int CNT_MAX  [4] = '{255, 255, 255, 3};

  // Reference model: bits collected since the last restart, as text.
  string ms   [4];
  string mpat [4];
  int    mcnt [4];
  bit    mq   [4];

  int   n_vec = 0;
  int   n_err = 0;
  logic q0_pre;

  typedef struct {
    bit         e;
    bit         dd;
    bit         ld;
    logic [3:0] pin;
    bit         clr;
    bit         eq;
    int         ef;
    int         ec;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic string bit_str(input bit b);
    string c;
    c = b ? "1" : "0";
    return c;
  endfunction

  function automatic bit m_hit(input int i, input bit e, input bit dd, input bit ld);
    string s;
    if (!e || ld) return 1'b0;
    s = {ms[i], bit_str(dd)};
    if (s.len() < 4) return 1'b0;
    return s.substr(s.len() - 4, s.len() - 1) == mpat[i];
  endfunction

  task automatic m_clock(input int i, input bit e, input bit dd, input bit ld,
                         input logic [3:0] pin, input bit clr, input bit hit);
    string s;
    if (ld) begin
      ms[i]   = "";
      mpat[i] = $sformatf("%04b", pin);
    end else if (e) begin
      s = {ms[i], bit_str(dd)};
      if (hit && !IS_OV[i]) s = "";
      else if (s.len() > 4) s = s.substr(s.len() - 4, s.len() - 1);
      ms[i] = s;
    end
    mq[i] = hit;
    if (clr) mcnt[i] = 0;
    else if (hit && mcnt[i] < CNT_MAX[i]) mcnt[i]++;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      ms[i]   = "";
      mpat[i] = "1011";
      mcnt[i] = 0;
      mq[i]   = 1'b0;
    end
  endtask

  // One clock: drive at negedge, check Q before the edge, state after it.
  task automatic step(input bit e, input bit dd, input bit ld, input logic [3:0] pin, input bit clr);
    bit h [4];
    @(negedge clk);
    en = e; d = dd; pat_ld = ld; pat_in = pin; cnt_clr = clr;
    #1;
    for (int i = 0; i < 4; i++) begin
      h[i] = m_hit(i, e, dd, ld);
      chk($sformatf("q_pre[%0d]", i), 32'(q_a[i]), 32'(IS_MEALY[i] ? h[i] : mq[i]));
    end
    q0_pre = q0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      m_clock(i, e, dd, ld, pin, clr, h[i]);
      chk($sformatf("fill[%0d]", i), 32'(fill_a[i]), 32'(ms[i].len()));
      chk($sformatf("cnt[%0d]", i), 32'(cnt_a[i]), 32'(mcnt[i]));
      if (!IS_MEALY[i]) chk($sformatf("q_post[%0d]", i), 32'(q_a[i]), 32'(mq[i]));
    end
  endtask

  initial begin
    // Default instance expectations: stream 1011011, load 0110, clr on hit, idle.
    tbl[0]  = '{1, 1, 0, 4'h0, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 4'h0, 0, 0, 2, 0};
    tbl[2]  = '{1, 1, 0, 4'h0, 0, 0, 3, 0};
    tbl[3]  = '{1, 1, 0, 4'h0, 0, 1, 4, 1};
    tbl[4]  = '{1, 0, 0, 4'h0, 0, 0, 4, 1};
    tbl[5]  = '{1, 1, 0, 4'h0, 0, 0, 4, 1};
    tbl[6]  = '{1, 1, 0, 4'h0, 0, 1, 4, 2};
    tbl[7]  = '{1, 1, 1, 4'h6, 0, 0, 0, 2};
    tbl[8]  = '{1, 0, 0, 4'h0, 0, 0, 1, 2};
    tbl[9]  = '{1, 1, 0, 4'h0, 0, 0, 2, 2};
    tbl[10] = '{1, 1, 0, 4'h0, 0, 0, 3, 2};
    tbl[11] = '{1, 0, 0, 4'h0, 0, 1, 4, 3};
    tbl[12] = '{1, 1, 0, 4'h0, 0, 0, 4, 3};
    tbl[13] = '{1, 1, 0, 4'h0, 0, 0, 4, 3};
    tbl[14] = '{1, 0, 0, 4'h0, 1, 1, 4, 0};
    tbl[15] = '{0, 1, 0, 4'h0, 0, 0, 4, 0};
    tbl[16] = '{1, 1, 0, 4'h0, 0, 0, 4, 0};

    rst = 1'b1; en = 1'b0; d = 1'b0; pat_ld = 1'b0; pat_in = 4'h0; cnt_clr = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_fill[%0d]", i), 32'(fill_a[i]), 32'd0);
      chk($sformatf("rst_cnt[%0d]", i), 32'(cnt_a[i]), 32'd0);
      chk($sformatf("rst_q[%0d]", i), 32'(q_a[i]), 32'd0);
    end

    for (int k = 0; k < 17; k++) begin
      step(tbl[k].e, tbl[k].dd, tbl[k].ld, tbl[k].pin, tbl[k].clr);
      chk($sformatf("tbl_q[%0d]", k), 32'(q0_pre), 32'(tbl[k].eq));
      chk($sformatf("tbl_fill[%0d]", k), 32'(f0), 32'(tbl[k].ef));
      chk($sformatf("tbl_cnt[%0d]", k), 32'(c0), 32'(tbl[k].ec));
    end

    // Reload 1011 and drive five matches: CNT_W=2 instance saturates at 3.
    step(1, 0, 1, 4'b1011, 0);
    repeat (5) begin
      step(1, 1, 0, 4'h0, 0); step(1, 0, 0, 4'h0, 0);
      step(1, 1, 0, 4'h0, 0); step(1, 1, 0, 4'h0, 0);
    end
    chk("sat_cnt3", 32'(c3), 32'd3);
    chk("nonov_cnt", 32'(c1), 32'd5);
    step(1, 0, 0, 4'h0, 0); step(1, 1, 0, 4'h0, 0); step(1, 1, 0, 4'h0, 1);
    chk("clr_on_hit_q", 32'(q0_pre), 32'd1);
    chk("clr_on_hit_cnt", 32'(c0), 32'd0);

    // Moore pulses with en=0 gaps between bits.
    step(1, 1, 0, 4'h0, 0); step(0, 0, 0, 4'h0, 0); step(1, 0, 0, 4'h0, 0);
    step(0, 1, 0, 4'h0, 0); step(0, 1, 0, 4'h0, 0); step(1, 1, 0, 4'h0, 0);
    step(0, 0, 0, 4'h0, 0); step(1, 1, 0, 4'h0, 0); step(0, 0, 0, 4'h0, 0);
    step(0, 0, 0, 4'h0, 0);

    // Asynchronous 1-unit reset pulse mid-cycle after a partial sequence.
    step(1, 1, 0, 4'h0, 0); step(1, 0, 0, 4'h0, 0); step(1, 1, 0, 4'h0, 0);
    #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_rst_fill[%0d]", i), 32'(fill_a[i]), 32'd0);
      chk($sformatf("mid_rst_cnt[%0d]", i), 32'(cnt_a[i]), 32'd0);
      chk($sformatf("mid_rst_q[%0d]", i), 32'(q_a[i]), 32'd0);
    end
    rst = 1'b0;
    m_reset();
    step(1, 1, 0, 4'h0, 0);
    chk("post_rst_single", 32'(q0_pre), 32'd0);
    step(1, 1, 0, 4'h0, 0); step(1, 0, 0, 4'h0, 0); step(1, 1, 0, 4'h0, 0);
    step(1, 1, 0, 4'h0, 0);
    chk("post_rst_hit", 32'(q0_pre), 32'd1);

    // Randomised traffic with occasional reloads and clears.
    for (int n = 0; n < 400; n++) begin
      bit         e, dd, ld, clr;
      logic [3:0] pin;
      e   = ($urandom_range(0, 3) != 0);
      dd  = 1'($urandom);
      ld  = ($urandom_range(0, 39) == 0);
      pin = ($urandom_range(0, 1) != 0) ? 4'b1011 : 4'($urandom);
      clr = ($urandom_range(0, 29) == 0);
      step(e, dd, ld, pin, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snail_seq_detector_param.md
Name: snail_seq_detector_param

Overview:
- Parametrised successor to the fixed-pattern snail sequence detector.
- Detects a PAT_W-bit serial pattern on D. The pattern is set by a parameter and can be reloaded at run time.
- Overlapping or non-overlapping detection and Mealy or Moore output timing are selected by parameters. A saturating match counter is included.
- Sits on the serial bit stream as a reusable lab building block, replacing the per-pattern hand-coded FSMs.

Parameters:
- PAT_W, 4, pattern length in bits, legal range 2..16.
- PATTERN, 4'b1011, reset value of the pattern register. MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping.
- MEALY, 1, 1 = combinational Mealy output, 0 = registered Moore output.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  system clock, rising edge.
- _rst  in  1  asynchronous reset, active-high.
- en  in  1  sample strobe. D is consumed only when en=1.
- D  in  1  serial data bit.
- pat_ld  in  1  load pat_in into the pattern register.
- pat_in  in  PAT_W  new pattern, MSB first-received.
- cnt_clr  in  1  synchronous clear of match_cnt.
- Q  out  1  match pulse.
- match_cnt  out  CNT_W  number of matches, saturating.
- fill  out  FW  number of valid history bits, 0..PAT_W, where FW = $clog2(PAT_W+1).

Behaviour:
- Reset (_rst=1, asynchronous):
  - pat <= PATTERN; hist <= 0; fill <= 0; match_cnt <= 0; Moore Q register <= 0.
  - Mealy Q is forced to 0 while reset is asserted.
- Internal state:
  - hist[PAT_W-1:0] holds the shift history, newest bit in LSB.
  - fill is a saturating counter acting as the FSM state, with states S0..S_PAT_W meaning "k bits collected".
- Sample step (en=1, pat_ld=0):
  - nhist = {hist[PAT_W-2:0], D}.
  - nfill = (fill==PAT_W) ? PAT_W : fill+1.
  - hit = (nfill==PAT_W) && (nhist==pat).
  - On the clock edge, hist <= nhist.
  - fill <= (hit && !OVERLAP) ? 0 : nfill.
- Idle step (en=0, pat_ld=0): hist and fill hold; hit=0.
- Output timing:
  - MEALY=1: Q = hit, combinational from en, D and registers. It is valid in the same cycle as the completing bit.
  - MEALY=0: Q register <= hit on every clock. Q is a 1-cycle pulse in the cycle after the completing bit and is 0 otherwise.
- Pattern load (pat_ld=1):
  - pat <= pat_in; hist <= 0; fill <= 0; Moore Q register <= 0.
  - pat_ld has priority over en. The concurrent D sample is discarded, hit=0, and Mealy Q=0.
- Match counter:
  - Increments on hit and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets it to 0. cnt_clr wins over a simultaneous hit, leaving the result at 0.
  - pat_ld does not clear the counter.
- Overlap semantics:
  - OVERLAP=1 keeps the history after a match, so a pattern suffix can start the next match.
  - OVERLAP=0 restarts collection from S0 after every match.
- Reset asserted mid-sequence discards the partial history immediately. There is no pending output.
- No X-propagation: all registers are reset, and the pattern compare uses full-width equality.

Decomposition:
- Shared package snail_pkg:
  - Mode constants SNAIL_OVERLAP / SNAIL_NONOVERLAP and SNAIL_MEALY / SNAIL_MOORE.
  - A function for FW (clog2 of PAT_W+1).
  - Default pattern constant SNAIL_PAT_DEFAULT = 4'b1011.
- One sub-module, snail_sat_counter (parameter W; ports clk, _rst, inc, clr, cnt), used for match_cnt.
- Keep a debug-only ASCII state name register txstate (64 bits, e.g. "S3") for waveform viewing. It is not a port.

Test Plan:
1. Default parameters (1011, overlap, Mealy), en=1, D stream 1,0,1,1,0,1,1 -> Q=1 in the same cycle as bits 4 and 7; match_cnt=2 afterward; fill=4 after bit 4.
2. OVERLAP=0 with the same stream -> Q=1 only at bit 4; fill shows 0 after bit 4, then 3 after bit 7; match_cnt=1.
3. MEALY=0 with the stream from scenario 1 -> Q pulses one clock after bits 4 and 7, each pulse exactly 1 cycle wide. Inserting en=0 gaps between bits delays hits but never drops them.
4. pat_ld with pat_in=4'b0110 asserted together with en=1, D=1 -> sample ignored, fill=0, Q=0. Then stream 0,1,1,0 -> hit at bit 4; match_cnt continues from its prior value.
5. CNT_W=2 with 5 consecutive matches of the stream 1,0,1,1 repeated -> match_cnt reaches 3 and holds. cnt_clr coinciding with a hit -> match_cnt=0.
6. _rst pulsed asynchronously (mid-cycle, 1 ns) after bits 1,0,1 -> fill=0, Q=0, match_cnt=0 immediately. A following single 1 does not produce a hit, and 1,0,1,1 after reset produces a hit at the 4th bit.
